// File: rtl/forwarding_hazard_unit_pkg.sv
// Shared types for the EX-stage forwarding/hazard unit.
// Select encodings, shadow tag entry, and small helpers.
package forwarding_hazard_unit_pkg;

    localparam int TAG_W = 8;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef struct packed {
        logic             valid;
        logic             regWrite;
        logic             memRead;
        logic [TAG_W-1:0] dest;
    } tagEntry_t;

    localparam tagEntry_t TAG_EMPTY = '0;

    typedef enum logic {
        RUN,
        HOLD
    } hazState_t;

    function automatic logic isProducer(tagEntry_t e);
        return e.valid && e.regWrite && (e.dest != '0);
    endfunction

    // A load still in EX cannot feed MEM-stage data; that case stalls instead.
    function automatic logic [1:0] fwdSel(
        logic uses,
        logic exHit,
        logic exLoad,
        logic memHit
    );
        if (!uses) return FWD_RF;
        if (exHit && !exLoad) return FWD_MEM;
        if (memHit) return FWD_WB;
        return FWD_RF;
    endfunction

endpackage

// File: rtl/forwarding_hazard_unit_if.sv
// ID-side decoded fields in, EX forward selects and stall controls out.
// Perf counters exist only when HAZARD_PERF_EN is defined.
interface forwarding_hazard_unit_if #(
    parameter int REG_ADDR_W = 5
);
    logic                  Freeze;
    logic                  ID_Valid;
    logic [REG_ADDR_W-1:0] ID_Rs;
    logic [REG_ADDR_W-1:0] ID_Rt;
    logic [REG_ADDR_W-1:0] ID_Rd;
    logic                  ID_UsesRs;
    logic                  ID_UsesRt;
    logic                  ID_RegDst;
    logic                  ID_RegWrite;
    logic                  ID_MemRead;
    logic                  ID_ALUSrc;
    logic                  ID_IsStore;
    logic [1:0]            ForwardA;
    logic [1:0]            ForwardB;
    logic                  ForwardC;
    logic                  Stall;
    logic                  Bubble;
`ifdef HAZARD_PERF_EN
    logic [31:0]           StallCount;
    logic [31:0]           FwdCount;
`endif

    modport master (
        output Freeze, ID_Valid, ID_Rs, ID_Rt, ID_Rd,
        output ID_UsesRs, ID_UsesRt, ID_RegDst,
        output ID_RegWrite, ID_MemRead, ID_ALUSrc, ID_IsStore,
        input  ForwardA, ForwardB, ForwardC, Stall, Bubble
`ifdef HAZARD_PERF_EN
        , input StallCount, FwdCount
`endif
    );

    modport slave (
        input  Freeze, ID_Valid, ID_Rs, ID_Rt, ID_Rd,
        input  ID_UsesRs, ID_UsesRt, ID_RegDst,
        input  ID_RegWrite, ID_MemRead, ID_ALUSrc, ID_IsStore,
        output ForwardA, ForwardB, ForwardC, Stall, Bubble
`ifdef HAZARD_PERF_EN
        , output StallCount, FwdCount
`endif
    );

endinterface

// File: rtl/hazard_tag_stage.sv
// One shadow-pipeline tag register: resettable, freezable, and able
// to load a bubble in place of its input.
module hazard_tag_stage
    import forwarding_hazard_unit_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      hold,
    input  logic      bubble,
    input  tagEntry_t d,
    output tagEntry_t q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= TAG_EMPTY;
        end else if (!hold) begin
            q <= bubble ? TAG_EMPTY : d;
        end
    end

endmodule

// File: rtl/forwarding_hazard_unit.sv
// Forward-select and load-use/store-data stall generator for EX.
// Define HAZARD_PERF_EN to add StallCount/FwdCount counters.
module forwarding_hazard_unit
    import forwarding_hazard_unit_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input logic Clk,
    input logic Rst,
    forwarding_hazard_unit_if.slave bus
);

    tagEntry_t idEntry;
    tagEntry_t exE;
    tagEntry_t memE;
    tagEntry_t wbE;

    logic [REG_ADDR_W-1:0] destSel;
    logic [TAG_W-1:0]      rsTag;
    logic [TAG_W-1:0]      rtTag;

    logic exHitRs;
    logic exHitRt;
    logic memHitRs;
    logic memHitRt;
    logic loadUse;
    logic storeData;
    logic stall;

    logic [1:0] fwdANext;
    logic [1:0] fwdBNext;
    logic       fwdCNext;
    logic [1:0] fwdA;
    logic [1:0] fwdB;
    logic       fwdC;

    hazState_t state;
    hazState_t stateNext;

    assign destSel = bus.ID_RegDst ? bus.ID_Rd : bus.ID_Rt;
    assign rsTag   = TAG_W'(bus.ID_Rs);
    assign rtTag   = TAG_W'(bus.ID_Rt);

    // Non-valid slots enter the shadow pipe fully zeroed.
    always_comb begin
        idEntry = TAG_EMPTY;
        if (bus.ID_Valid) begin
            idEntry.valid    = 1'b1;
            idEntry.regWrite = bus.ID_RegWrite;
            idEntry.memRead  = bus.ID_MemRead;
            idEntry.dest     = TAG_W'(destSel);
        end
    end

    assign exHitRs  = isProducer(exE) && (exE.dest == rsTag);
    assign exHitRt  = isProducer(exE) && (exE.dest == rtTag);
    assign memHitRs = isProducer(memE) && (memE.dest == rsTag);
    assign memHitRt = isProducer(memE) && (memE.dest == rtTag);

    assign loadUse = exE.memRead &&
                     ((bus.ID_UsesRs && exHitRs) ||
                      (bus.ID_UsesRt && !bus.ID_ALUSrc && exHitRt));
    assign storeData = bus.ID_IsStore && exHitRt;
    assign stall     = bus.ID_Valid && (loadUse || storeData);

    assign fwdANext = fwdSel(bus.ID_Valid && bus.ID_UsesRs,
                             exHitRs, exE.memRead, memHitRs);
    assign fwdBNext = bus.ID_ALUSrc ? FWD_RF :
                      fwdSel(bus.ID_Valid && bus.ID_UsesRt,
                             exHitRt, exE.memRead, memHitRt);
    assign fwdCNext = bus.ID_Valid && bus.ID_IsStore && memHitRt;

    hazard_tag_stage uExTag (
        .clk    (Clk),
        .rst    (Rst),
        .hold   (bus.Freeze),
        .bubble (stall),
        .d      (idEntry),
        .q      (exE)
    );

    hazard_tag_stage uMemTag (
        .clk    (Clk),
        .rst    (Rst),
        .hold   (bus.Freeze),
        .bubble (1'b0),
        .d      (exE),
        .q      (memE)
    );

    hazard_tag_stage uWbTag (
        .clk    (Clk),
        .rst    (Rst),
        .hold   (bus.Freeze),
        .bubble (1'b0),
        .d      (memE),
        .q      (wbE)
    );

    always_ff @(posedge Clk) begin
        if (Rst) begin
            fwdA <= FWD_RF;
            fwdB <= FWD_RF;
            fwdC <= 1'b0;
        end else if (!bus.Freeze) begin
            fwdA <= stall ? FWD_RF : fwdANext;
            fwdB <= stall ? FWD_RF : fwdBNext;
            fwdC <= stall ? 1'b0 : fwdCNext;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= RUN;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        if (!bus.Freeze) begin
            stateNext = stall ? HOLD : RUN;
        end
    end

    // HOLD always follows a bubble into EX, so the retry cannot stall again.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            assert (state == RUN || !exE.valid);
            assert (memE.valid || memE == TAG_EMPTY);
            assert (wbE.valid || wbE == TAG_EMPTY);
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] stallCnt;
    logic [31:0] fwdCnt;
    logic        fwdLoad;

    assign fwdLoad = !stall &&
                     ((fwdANext != FWD_RF) || (fwdBNext != FWD_RF) || fwdCNext);

    always_ff @(posedge Clk) begin
        if (Rst) begin
            stallCnt <= '0;
            fwdCnt   <= '0;
        end else if (!bus.Freeze) begin
            if (stall) stallCnt <= stallCnt + 32'd1;
            if (fwdLoad) fwdCnt <= fwdCnt + 32'd1;
        end
    end

    assign bus.StallCount = stallCnt;
    assign bus.FwdCount   = fwdCnt;
`endif

    assign bus.ForwardA = fwdA;
    assign bus.ForwardB = fwdB;
    assign bus.ForwardC = fwdC;
    assign bus.Stall    = stall;
    assign bus.Bubble   = stall;

endmodule
